// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
// Op codes, FSM states and the default datapath width.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Divide path is built only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_next;

  // Multiply: add multiplicand on multiplier LSB, keep carry, shift right.
  always_comb begin
    sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]};
    if (acc_in[0]) begin
      sum = sum + {1'b0, operand};
    end
    mul_next = {sum, acc_in[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     top;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] div_next;
  logic               unused_diff;

  assign unused_diff = diff[WIDTH];

  // Divide: shift rem:quo left, trial-subtract, restore on borrow.
  always_comb begin
    top  = acc_in[2*WIDTH-1:WIDTH-1];
    diff = {1'b0, top} - {2'b00, operand};
    if (diff[WIDTH+1]) begin
      div_next = {top[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
    end
  end

  assign acc_out = is_div ? div_next : mul_next;
`else
  logic unused_is_div;

  assign unused_is_div = is_div;
  assign acc_out = mul_next;
`endif

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit beside EX, with HI/LO.
// Divide support is enabled by defining MULDIV_DIV_EN.
module ex_muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e             state;
  logic [CW-1:0]      count;
  logic               is_div_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;

  logic               is_div;
  logic               sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_fix;

`ifdef MULDIV_DIV_EN
  logic               neg_r;
  logic               dz;
  logic               b_zero;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
`endif

  assign busy = (state != IDLE);

  // Decode request and take operand magnitudes.
  always_comb begin
    is_div = (op == OP_DIV) || (op == OP_DIVU);
    sgn    = (op == OP_MULT) || (op == OP_DIV);
    a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag  = (sgn && b[WIDTH-1]) ? -b : b;
  end

  // Sign fix-up of the finished accumulator.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
  end

`ifdef MULDIV_DIV_EN
  // Quotient/remainder sign fix-up and zero-divisor detect.
  always_comb begin
    b_zero  = (b == '0);
    quo_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix = neg_r ? -acc[2*WIDTH-1:WIDTH]
                    : acc[2*WIDTH-1:WIDTH];
  end
`else
  assign div_by_zero = 1'b0;
`endif

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_in (acc),
    .operand(opnd),
    .is_div (is_div_q),
    .acc_out(acc_next)
  );

  // FSM, iteration counter and HI/LO commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      acc      <= '0;
      opnd     <= '0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MULDIV_DIV_EN
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_by_zero <= 1'b0;
`endif
      if (flush) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              is_div_q <= is_div;
              count    <= '0;
              neg_q    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
              if (is_div) begin
                acc  <= {{WIDTH{1'b0}}, a_mag};
                opnd <= b_mag;
              end else begin
                acc  <= {{WIDTH{1'b0}}, b_mag};
                opnd <= a_mag;
              end
`ifdef MULDIV_DIV_EN
              neg_r <= sgn & a[WIDTH-1];
              dz    <= is_div & b_zero;
              if (is_div && b_zero) begin
                acc   <= {a, {WIDTH{1'b0}}};
                state <= FIX;
              end else begin
                state <= CALC;
              end
`else
              state <= is_div ? FIX : CALC;
`endif
            end
          end
          CALC: begin
            acc   <= acc_next;
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) begin
              state <= FIX;
            end
          end
          FIX: begin
            state <= IDLE;
            done  <= 1'b1;
            if (!is_div_q) begin
              {hi, lo} <= prod_fix;
            end
`ifdef MULDIV_DIV_EN
            else if (dz) begin
              hi          <= acc[2*WIDTH-1:WIDTH];
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer.
// Covers the MULDIV_DIV_EN and default builds.
module tb_ex_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  ex_muldiv_sequencer #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result of one operation, by plain arithmetic.
  function automatic void model(input logic [1:0] o,
                                input logic [31:0] x,
                                input logic [31:0] y,
                                inout logic [31:0] h,
                                inout logic [31:0] l,
                                output logic dz,
                                output int lat);
    longint      p;
    logic [63:0] pu;
    longint      la, lb, q, r;
    dz  = 1'b0;
    lat = 33;
    p   = 0;
    pu  = '0;
    la  = 0;
    lb  = 0;
    q   = 0;
    r   = 0;
    case (o)
      2'b00: begin
        p = longint'($signed(x)) * longint'($signed(y));
        {h, l} = p;
      end
      2'b01: begin
        pu = {32'b0, x} * {32'b0, y};
        {h, l} = pu;
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (y == 0) begin
          h = x;
          l = '1;
          dz = 1'b1;
          lat = 1;
        end else if (o == 2'b10) begin
          la = longint'($signed(x));
          lb = longint'($signed(y));
          q = la / lb;
          r = la % lb;
          l = q[31:0];
          h = r[31:0];
        end else begin
          l = x / y;
          h = x % y;
        end
`else
        lat = 1;
`endif
      end
    endcase
  endfunction

  // Issue at the current negedge; return at the negedge showing Done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input string tag);
    logic dz;
    int   lat_e;
    int   lat;
    int   bc;
    model(o, x, y, m_hi, m_lo, dz, lat_e);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bc = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(lat_e));
    check({tag, "/busy_cycles"}, 64'(bc), 64'(lat_e));
    check({tag, "/busy_in_done"}, 64'(busy), 64'(0));
    check({tag, "/hi"}, 64'(hi), 64'(m_hi));
    check({tag, "/lo"}, 64'(lo), 64'(m_lo));
    check({tag, "/dbz"}, 64'(div_by_zero), 64'(dz));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    #1;
    check("reset/busy", 64'(busy), 64'(0));
    check("reset/done", 64'(done), 64'(0));
    check("reset/dbz", 64'(div_by_zero), 64'(0));
    check("reset/hi", 64'(hi), 64'(0));
    check("reset/lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(2'b00, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
`ifdef MULDIV_DIV_EN
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_op(2'b11, 32'd7, 32'd0, "divu_by0");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_wrap");
    do_op(2'b10, 32'd100, 32'd0, "div_by0");
`else
    do_op(2'b10, 32'd9, 32'd3, "div_off");
    do_op(2'b11, 32'd9, 32'd0, "divu_off");
`endif

    // Flush at cycle 10 of a MULT, then restart.
    @(negedge clk);
    op = 2'b00;
    a = 32'd12345;
    b = 32'd678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush/busy", 64'(busy), 64'(0));
    check("flush/done", 64'(done), 64'(0));
    check("flush/hi", 64'(hi), 64'(m_hi));
    check("flush/lo", 64'(lo), 64'(m_lo));
    do_op(2'b01, 32'd40000, 32'd50000, "after_flush");

    // Flush together with Start in IDLE.
    @(negedge clk);
    op = 2'b00;
    a = 32'd5;
    b = 32'd5;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_start/busy", 64'(busy), 64'(0));

    // Flush in the FIX cycle: no commit, no Done.
    op = 2'b00;
    a = 32'd77;
    b = 32'd99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    check("fix/busy", 64'(busy), 64'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_fix/done", 64'(done), 64'(0));
    check("flush_fix/hi", 64'(hi), 64'(m_hi));
    check("flush_fix/lo", 64'(lo), 64'(m_lo));

    // Back-to-back: second Start in the first Done cycle.
    @(negedge clk);
    do_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, "b2b_1");
    do_op(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, "b2b_2");

    // Randomised operations against the model.
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      do_op(ro, ra, rb, $sformatf("rand%0d", i));
    end

    // Reset mid-operation clears everything at once.
    @(negedge clk);
    op = 2'b10;
    a = 32'd1000;
    b = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset/busy", 64'(busy), 64'(0));
    check("midreset/done", 64'(done), 64'(0));
    check("midreset/dbz", 64'(div_by_zero), 64'(0));
    check("midreset/hi", 64'(hi), 64'(0));
    check("midreset/lo", 64'(lo), 64'(0));
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
